scan_chain_tester: RTL and testbench

//  On-chip scan test sequencer for scan-inserted netlists.
//  - Drives CHAINS parallel scan chains of CHAIN_LEN flops each with a

---
 rtl/scan_chain_tester.sv | 153 +++++++++++++++
 tb/tb_scan_chain_tester.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/scan_chain_tester.sv
// Multi-chain scan sequencer: load pattern, capture, unload and compare, with per-chain pass/fail.
// Optional MISR signature output when SCAN_CHAIN_TESTER_MISR_EN is defined.
module scan_chain_tester #(
   parameter int CHAINS         = 2,
   parameter int CHAIN_LEN      = 8,
   parameter int CAPTURE_CYCLES = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [CHAINS*CHAIN_LEN-1:0] pattern_in,
   input  logic [CHAINS*CHAIN_LEN-1:0] expected_in,
   input  logic [CHAINS-1:0]           scan_out,
   output logic                        scan_enable,
   output logic [CHAINS-1:0]           scan_in,
   output logic                        busy,
   output logic                        done,
   output logic                        fail,
   output logic [CHAINS-1:0]           fail_map,
   output logic [CHAINS*CHAIN_LEN-1:0] response_out
`ifdef SCAN_CHAIN_TESTER_MISR_EN
   ,
   output logic [15:0]                 signature
`endif
);

   localparam int TOTAL = CHAINS * CHAIN_LEN;
   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int CAP_W = (CAPTURE_CYCLES > 0) ? $clog2(CAPTURE_CYCLES + 1) : 1;
   localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'((CAPTURE_CYCLES > 0) ? CAPTURE_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;

   state_t             state, state_nxt;
   logic [TOTAL-1:0]   pattern_q;
   logic [TOTAL-1:0]   expected_q;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CAP_W-1:0]   cap_cnt;
   logic [IDX_W-1:0]   idx [CHAINS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (bit_cnt == BIT_LAST) state_nxt = (CAPTURE_CYCLES == 0) ? UNLOAD : CAPTURE;
            CAPTURE: if (cap_cnt == CAP_LAST) state_nxt = UNLOAD;
            UNLOAD:  if (bit_cnt == BIT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Bit position k of chain c within the packed pattern/expected/response vectors.
   always_comb begin
      for (int c = 0; c < CHAINS; c++) begin
         idx[c] = IDX_W'(c * CHAIN_LEN) + IDX_W'(bit_cnt);
      end
   end

   always_comb begin
      scan_enable = 1'b0;
      scan_in     = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         LOAD: begin
            scan_enable = 1'b1;
            busy        = 1'b1;
            for (int c = 0; c < CHAINS; c++) scan_in[c] = pattern_q[idx[c]];
         end
         CAPTURE: busy = 1'b1;
         UNLOAD: begin
            scan_enable = 1'b1;
            busy        = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign fail = |fail_map;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q    <= '0;
         expected_q   <= '0;
         response_out <= '0;
         fail_map     <= '0;
         bit_cnt      <= '0;
         cap_cnt      <= '0;
      end else if (abort) begin
         // Partial response is kept for debug; verdict is discarded.
         fail_map <= '0;
         bit_cnt  <= '0;
         cap_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pattern_q    <= pattern_in;
                  expected_q   <= expected_in;
                  response_out <= '0;
                  fail_map     <= '0;
                  bit_cnt      <= '0;
                  cap_cnt      <= '0;
               end
            end
            LOAD: bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + CNT_W'(1);
            CAPTURE: cap_cnt <= (cap_cnt == CAP_LAST) ? '0 : cap_cnt + CAP_W'(1);
            UNLOAD: begin
               for (int c = 0; c < CHAINS; c++) begin
                  response_out[idx[c]] <= scan_out[c];
                  if (scan_out[c] != expected_q[idx[c]]) fail_map[c] <= 1'b1;
               end
               bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SCAN_CHAIN_TESTER_MISR_EN
   logic [15:0] misr_nxt;

   // Galois form of x^16+x^12+x^5+1, then fold the unloaded bits into the low end.
   always_comb begin
      misr_nxt = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000);
      for (int c = 0; c < CHAINS && c < 16; c++) begin
         misr_nxt[c] = misr_nxt[c] ^ scan_out[c];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       signature <= '0;
      else if (abort)                                signature <= signature;
      else if (state == IDLE && start)               signature <= '0;
      else if (state == UNLOAD)                      signature <= misr_nxt;
   end
`endif

endmodule

// File: tb/tb_scan_chain_tester.sv
// Directed bench: two testers (CAPTURE_CYCLES 0 and 1) driving behavioural 8-bit scan chains.
module tb_scan_chain_tester;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start0, start1, abort0, abort1, sel;
   logic [15:0] pattern, expected;
   logic [1:0]  so0, so1, si0, si1, fm0, fm1;
   logic        se0, se1, busy0, busy1, done0, done1, fail0, fail1;
   logic [15:0] resp0, resp1;
`ifdef SCAN_CHAIN_TESTER_MISR_EN
   logic [15:0] sig0, sig1;
`endif
   logic [7:0]  ch0 [2];
   logic [7:0]  ch1 [2];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [4:0]  ab_snap;
   int          dc, nd, sl;
   logic [15:0] sig_a, sig_b;

   scan_chain_tester #(.CHAINS(2), .CHAIN_LEN(8), .CAPTURE_CYCLES(0)) u_t0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0),
      .pattern_in(pattern), .expected_in(expected), .scan_out(so0),
      .scan_enable(se0), .scan_in(si0), .busy(busy0), .done(done0),
      .fail(fail0), .fail_map(fm0), .response_out(resp0)
`ifdef SCAN_CHAIN_TESTER_MISR_EN
      , .signature(sig0)
`endif
   );

   scan_chain_tester #(.CHAINS(2), .CHAIN_LEN(8), .CAPTURE_CYCLES(1)) u_t1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .pattern_in(pattern), .expected_in(expected), .scan_out(so1),
      .scan_enable(se1), .scan_in(si1), .busy(busy1), .done(done1),
      .fail(fail1), .fail_map(fm1), .response_out(resp1)
`ifdef SCAN_CHAIN_TESTER_MISR_EN
      , .signature(sig1)
`endif
   );

   // Chain model: shift in at MSB, scan_out at bit 0; a functional cycle inverts every flop.
   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (se0)        ch0[c] <= {si0[c], ch0[c][7:1]};
         else if (busy0) ch0[c] <= ~ch0[c];
      end
   end
   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (se1)        ch1[c] <= {si1[c], ch1[c][7:1]};
         else if (busy1) ch1[c] <= ~ch1[c];
      end
   end
   assign so0 = {ch0[1][0], ch0[0][0]};
   assign so1 = {ch1[1][0], ch1[0][0]};

   wire        m_done = sel ? done1 : done0;
   wire        m_busy = sel ? busy1 : busy0;
   wire        m_se   = sel ? se1   : se0;
   wire [1:0]  m_fm   = sel ? fm1   : fm0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic set_start(input logic v);
      if (sel) start1 = v; else start0 = v;
   endtask

   task automatic set_abort(input logic v);
      if (sel) abort1 = v; else abort0 = v;
   endtask

   // Cycle n is the n-th clock period after the start-accept edge; outputs sampled on negedge.
   task automatic run_test(input logic s, input logic [15:0] pat, input logic [15:0] exp,
                           input int restart_at, input int abort_at,
                           output int done_cyc, output int n_done, output int se_low);
      sel = s; pattern = pat; expected = exp;
      done_cyc = 0; n_done = 0; se_low = 0;
      @(negedge clk); set_start(1'b1);
      @(posedge clk); #1 set_start(1'b0);
      for (int cyc = 1; cyc <= 24; cyc++) begin
         @(negedge clk);
         if (m_done) begin n_done++; done_cyc = cyc; end
         if (m_busy && !m_se) se_low++;
         if (abort_at > 0 && cyc == abort_at + 1) begin
            ab_snap = {m_busy, m_se, m_fm, m_done};
            set_abort(1'b0);
         end
         if (cyc == abort_at) set_abort(1'b1);
         set_start(cyc == restart_at);
      end
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
      sel = 1'b0; pattern = '0; expected = '0; ab_snap = '1;
      repeat (2) @(negedge clk);
      chk("rst_ctl", {busy0, done0, se0, fail0, busy1, done1, se1, fail1}, 0);
      chk("rst_scan_in", {si0, si1}, 0);
      chk("rst_fail_map", {fm0, fm1}, 0);
      chk("rst_response", {resp0, resp1}, 0);
      rst = 1'b0;

      run_test(1'b0, 16'hA995, 16'hA995, 0, 0, dc, nd, sl);
      chk("t1_response", resp0, 16'hA995);
      chk("t1_fail", fail0, 0);
      chk("t1_done_cycle", dc, 17);
      chk("t1_done_count", nd, 1);
      chk("t1_se_low", sl, 0);

      run_test(1'b1, 16'h00FF, 16'hFF00, 0, 0, dc, nd, sl);
      chk("t2_response", resp1, 16'hFF00);
      chk("t2_fail_map", fm1, 2'b00);
      chk("t2_done_cycle", dc, 18);
      chk("t2_se_low", sl, 1);
`ifdef SCAN_CHAIN_TESTER_MISR_EN
      sig_a = sig1;
`endif

      run_test(1'b1, 16'h00FF, 16'hFF00, 5, 0, dc, nd, sl);
      chk("t4_done_count", nd, 1);
      chk("t4_done_cycle", dc, 18);
      chk("t4_response", resp1, 16'hFF00);
      chk("t4_fail_map", fm1, 2'b00);

      run_test(1'b1, 16'h00FF, 16'hFF08, 0, 0, dc, nd, sl);
      chk("t3_fail", fail1, 1);
      chk("t3_fail_map", fm1, 2'b01);
      chk("t3_response", resp1, 16'hFF00);
      repeat (3) @(negedge clk);
      chk("t3_hold_idle", {fail1, fm1}, 3'b101);

      run_test(1'b1, 16'h00FF, 16'hFF08, 0, 3, dc, nd, sl);
      chk("t5_after_abort", ab_snap, 0);
      chk("t5_no_done", nd, 0);
      run_test(1'b1, 16'h00FF, 16'hFF00, 0, 0, dc, nd, sl);
      chk("t5_rerun_response", resp1, 16'hFF00);
      chk("t5_rerun_done_cycle", dc, 18);
      chk("t5_rerun_fail_map", fm1, 2'b00);
`ifdef SCAN_CHAIN_TESTER_MISR_EN
      sig_b = sig1;
      chk("misr_nonzero", sig_a != 16'h0, 1);
      chk("misr_repeat", sig_b, sig_a);
`endif

      sel = 1'b1; pattern = 16'h00FF; expected = 16'hFF00;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      repeat (12) @(negedge clk);
      chk("t6_mid_unload_busy", {busy1, se1}, 2'b11);
      #1 rst = 1'b1;
      #1;
      chk("t6_async_ctl", {busy1, se1, done1, fail1}, 0);
      chk("t6_async_data", {si1, fm1, resp1}, 0);
`ifdef SCAN_CHAIN_TESTER_MISR_EN
      chk("t6_signature", sig1, 0);
`endif
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
